// File: rtl/mips_pkg.sv
// Shared ALU opcode map, datapath width and HI/LO sequencer state encoding.
package mips_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_AND   = 5'd4;
  localparam logic [4:0] OP_OR    = 5'd5;
  localparam logic [4:0] OP_XOR   = 5'd6;
  localparam logic [4:0] OP_NOR   = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_MULT  = 5'd11;
  localparam logic [4:0] OP_MULTU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_SLT   = 5'd15;
  localparam logic [4:0] OP_SLTU  = 5'd16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  function automatic logic is_div(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_div(op);
  endfunction

endpackage

// File: rtl/hilo_unit_if.sv
// EX-stage side of the HI/LO unit: op issue, MT/MF requests and status.
interface hilo_unit_if import mips_pkg::*; #(parameter int data_width = DATA_WIDTH);

  logic                  start;
  logic [4:0]            alu_opcode;
  logic [data_width-1:0] alu_result;
  logic [data_width-1:0] alu_hi;
  logic [data_width-1:0] in_s2;
  logic                  mthi;
  logic                  mtlo;
  logic [data_width-1:0] mt_data;
  logic                  mf_req;
  logic                  mf_sel;
  logic [data_width-1:0] mf_data;
  logic                  stall;
  logic                  busy;
  logic                  div_zero;
  logic [data_width-1:0] hi_out;
  logic [data_width-1:0] lo_out;

  modport master (
    output start, alu_opcode, alu_result, alu_hi, in_s2,
    output mthi, mtlo, mt_data, mf_req, mf_sel,
    input  mf_data, stall, busy, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, alu_opcode, alu_result, alu_hi, in_s2,
    input  mthi, mtlo, mt_data, mf_req, mf_sel,
    output mf_data, stall, busy, div_zero, hi_out, lo_out
  );

endinterface

// File: rtl/hilo_regs.sv
// Architectural HI/LO pair: MT writes from IDLE, whole-pair commit from the sequencer.
module hilo_regs import mips_pkg::*; #(
  parameter int data_width = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mt_hi_we,
  input  logic                  mt_lo_we,
  input  logic [data_width-1:0] mt_data,
  input  logic                  commit_we,
  input  logic [data_width-1:0] commit_hi,
  input  logic [data_width-1:0] commit_lo,
  input  logic                  rd_sel,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo,
  output logic [data_width-1:0] rd_data
);

  logic [data_width-1:0] hi_q, hi_d;
  logic [data_width-1:0] lo_q, lo_d;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (mt_hi_we) hi_d = mt_data;
    if (mt_lo_we) lo_d = mt_data;
    if (commit_we) begin
      hi_d = commit_hi;
      lo_d = commit_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // read sees the pre-edge value, so a same-cycle MT is not forwarded
  assign rd_data = rd_sel ? hi_q : lo_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO capture for mult/div with a latency window, interlock and divide-by-zero suppression.
module hilo_unit import mips_pkg::*; #(
  parameter int data_width = DATA_WIDTH,
  parameter int MULT_LAT   = 4,
  parameter int DIV_LAT    = 12
) (
  input logic       clk,
  input logic       rst_n,
  hilo_unit_if.slave bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [0:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [data_width-1:0] shadow_hi_q, shadow_hi_d;
  logic [data_width-1:0] shadow_lo_q, shadow_lo_d;
  logic                  dz_q, dz_d;
  logic                  div_zero_q, div_zero_d;
  logic [data_width-1:0] mf_data_q, mf_data_d;

  logic                  is_idle, is_busy, md_op, accept, commit;
  logic [data_width-1:0] rd_data, hi_val, lo_val;

  assign is_idle = (state_q == ST_IDLE);
  assign is_busy = (state_q == ST_BUSY);
  assign md_op   = is_muldiv(bus.alu_opcode);
  assign accept  = is_idle && bus.start && md_op;
  assign commit  = is_busy && (cnt_q == CNT_W'(1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shadow_hi_d = shadow_hi_q;
    shadow_lo_d = shadow_lo_q;
    dz_d        = dz_q;
    if (is_idle) begin
      if (accept) begin
        state_d     = ST_BUSY;
        shadow_hi_d = bus.alu_hi;
        shadow_lo_d = bus.alu_result;
        dz_d        = is_div(bus.alu_opcode) && (bus.in_s2 == '0);
        cnt_d       = is_div(bus.alu_opcode) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (commit) state_d = ST_IDLE;
    end
    div_zero_d = commit && dz_q;
    mf_data_d  = (is_idle && bus.mf_req) ? rd_data : mf_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shadow_hi_q <= '0;
      shadow_lo_q <= '0;
      dz_q        <= 1'b0;
      div_zero_q  <= 1'b0;
      mf_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_hi_q <= shadow_hi_d;
      shadow_lo_q <= shadow_lo_d;
      dz_q        <= dz_d;
      div_zero_q  <= div_zero_d;
      mf_data_q   <= mf_data_d;
    end
  end

  hilo_regs #(.data_width(data_width)) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .mt_hi_we  (is_idle && bus.mthi),
    .mt_lo_we  (is_idle && bus.mtlo),
    .mt_data   (bus.mt_data),
    .commit_we (commit && !dz_q),
    .commit_hi (shadow_hi_q),
    .commit_lo (shadow_lo_q),
    .rd_sel    (bus.mf_sel),
    .hi        (hi_val),
    .lo        (lo_val),
    .rd_data   (rd_data)
  );

  assign bus.busy     = is_busy;
  assign bus.stall    = is_busy && (bus.mf_req || bus.mthi || bus.mtlo || (bus.start && md_op));
  assign bus.div_zero = div_zero_q;
  assign bus.mf_data  = mf_data_d;
  assign bus.hi_out   = hi_val;
  assign bus.lo_out   = lo_val;

endmodule

// File: tb/tb_hilo_unit.sv
// Directed bench for hilo_unit; MF reads are checked by a scoreboard monitor.
module tb_hilo_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] exp_q[$];

  hilo_unit_if #(.data_width(32)) bus_if ();

  hilo_unit #(.data_width(32), .MULT_LAT(4), .DIV_LAT(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // monitor: a read is performed in any non-stalled cycle with mf_req
  always @(negedge clk) begin
    if (rst_n && bus_if.mf_req && !bus_if.stall) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL mf_read_unexpected: got %h expected none", bus_if.mf_data);
      end else begin
        chk("mf_read", bus_if.mf_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] op, input logic [31:0] hi, input logic [31:0] lo,
                       input logic [31:0] s2);
    bus_if.start      = 1'b1;
    bus_if.alu_opcode = op;
    bus_if.alu_hi     = hi;
    bus_if.alu_result = lo;
    bus_if.in_s2      = s2;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!bus_if.busy) break;
      n++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int viol;
    bus_if.start = 1'b0;  bus_if.alu_opcode = OP_ADD;
    bus_if.alu_hi = '0;   bus_if.alu_result = '0;  bus_if.in_s2 = '0;
    bus_if.mthi = 1'b0;   bus_if.mtlo = 1'b0;      bus_if.mt_data = '0;
    bus_if.mf_req = 1'b0; bus_if.mf_sel = 1'b0;

    tick(); tick();
    rst_n = 1'b1;

    // reset state and reads of cleared registers
    bus_if.mf_req = 1'b1; bus_if.mf_sel = 1'b1; exp_q.push_back(32'h0);
    @(negedge clk);
    chk("rst_stall", bus_if.stall, 0);
    chk("rst_busy", bus_if.busy, 0);
    chk("rst_hi", bus_if.hi_out, 0);
    chk("rst_lo", bus_if.lo_out, 0);
    chk("rst_div_zero", bus_if.div_zero, 0);
    tick();
    bus_if.mf_sel = 1'b0; exp_q.push_back(32'h0);
    tick();
    bus_if.mf_req = 1'b0;

    // MULT with a stalled read of LO
    issue(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h0);
    @(negedge clk);
    chk("mult_issue_stall", bus_if.stall, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (c == 1) bus_if.start = 1'b0;
      if (c == 2) begin
        bus_if.mf_req = 1'b1; bus_if.mf_sel = 1'b0; exp_q.push_back(32'hFFFF_FFFD);
      end
      @(negedge clk);
      chk("mult_busy", bus_if.busy, (c <= 4) ? 32'd1 : 32'd0);
      if (c == 2) chk("mult_stall", bus_if.stall, 1);
      if (c == 4) chk("mult_lo_pre", bus_if.lo_out, 0);
    end
    chk("mult_hi", bus_if.hi_out, 32'hFFFF_FFFF);
    chk("mult_lo", bus_if.lo_out, 32'hFFFF_FFFD);
    tick();
    bus_if.mf_req = 1'b0;

    // DIVU, with a DIV held upstream while busy
    issue(OP_DIVU, 32'h2, 32'h5555_5552, 32'h3);
    for (int c = 1; c <= 13; c++) begin
      tick();
      if (c == 1) bus_if.start = 1'b0;
      if (c == 3) issue(OP_DIV, 32'h11, 32'h22, 32'h5);
      @(negedge clk);
      chk("divu_busy", bus_if.busy, (c <= 12) ? 32'd1 : 32'd0);
      if (c >= 3) chk("divu_stall", bus_if.stall, (c <= 12) ? 32'd1 : 32'd0);
    end
    chk("divu_hi", bus_if.hi_out, 32'h2);
    chk("divu_lo", bus_if.lo_out, 32'h5555_5552);
    tick();
    bus_if.start = 1'b0;
    run_busy(n);
    chk("div2_len", n, 12);
    chk("div2_hi", bus_if.hi_out, 32'h11);
    chk("div2_lo", bus_if.lo_out, 32'h22);
    tick();
    bus_if.mf_req = 1'b1; bus_if.mf_sel = 1'b0; exp_q.push_back(32'h22);
    tick();
    bus_if.mf_sel = 1'b1; exp_q.push_back(32'h11);
    tick();
    bus_if.mf_req = 1'b0;

    // divide by zero leaves HI/LO alone and pulses div_zero once
    bus_if.mthi = 1'b1; bus_if.mt_data = 32'h7;
    tick();
    bus_if.mthi = 1'b0; bus_if.mtlo = 1'b1; bus_if.mt_data = 32'h9;
    tick();
    bus_if.mtlo = 1'b0;
    @(negedge clk);
    chk("mt_hi", bus_if.hi_out, 32'h7);
    chk("mt_lo", bus_if.lo_out, 32'h9);
    tick();
    issue(OP_DIV, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 32'h0);
    tick();
    bus_if.start = 1'b0;
    run_busy(n);
    chk("dz_len", n, 12);
    chk("dz_hi", bus_if.hi_out, 32'h7);
    chk("dz_lo", bus_if.lo_out, 32'h9);
    chk("dz_pulse", bus_if.div_zero, 1);
    tick();
    @(negedge clk);
    chk("dz_pulse_end", bus_if.div_zero, 0);

    // read-before-write on HI in the same IDLE cycle
    tick();
    bus_if.mthi = 1'b1; bus_if.mt_data = 32'h1234_5678;
    bus_if.mf_req = 1'b1; bus_if.mf_sel = 1'b1; exp_q.push_back(32'h7);
    tick();
    bus_if.mthi = 1'b0; exp_q.push_back(32'h1234_5678);
    tick();
    bus_if.mf_req = 1'b0;
    @(negedge clk);
    chk("mf_hold", bus_if.mf_data, 32'h1234_5678);

    // read + start together, then reset mid-operation
    tick();
    issue(OP_MULT, 32'hDEAD, 32'hBEEF, 32'h0);
    bus_if.mf_req = 1'b1; bus_if.mf_sel = 1'b0; exp_q.push_back(32'h9);
    tick();
    bus_if.start = 1'b0; bus_if.mf_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy_pre", bus_if.busy, 1);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", bus_if.busy, 0);
    chk("rst_mid_hi", bus_if.hi_out, 0);
    chk("rst_mid_lo", bus_if.lo_out, 0);
    chk("rst_mid_mf_data", bus_if.mf_data, 0);
    viol = 0;
    for (int c = 0; c < 15; c++) begin
      tick();
      @(negedge clk);
      if (bus_if.div_zero || bus_if.busy || bus_if.hi_out != 0 || bus_if.lo_out != 0) viol++;
    end
    chk("rst_mid_no_commit", viol, 0);

    tick(); tick();
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Sits directly downstream of the EX-stage ALU and captures the ALU's {hi, result} pair for MULT/MULTU/DIV/DIVU into the architectural HI/LO registers.
- Models the real multi-cycle latency of multiply and divide with a busy window.
- Generates the interlock (stall) for MFHI/MFLO/MTHI/MTLO and for back-to-back mult/div issued while busy.
- Detects divide-by-zero and suppresses the HI/LO update when it occurs.

Parameters:
data_width, 32, width of operands, HI and LO
MULT_LAT, 4, cycles from MULT/MULTU accept to HI/LO commit (>=1)
DIV_LAT, 12, cycles from DIV/DIVU accept to HI/LO commit (>=1)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  reset, synchronous, active-low
start  in  1  EX issues an op to this unit this cycle
alu_opcode  in  5  ALU opcode of the issued op (MULT=11, MULTU=12, DIV=13, DIVU=14)
alu_result  in  data_width  ALU result (LO part / quotient)
alu_hi  in  data_width  ALU hi output (HI part / remainder)
in_s2  in  data_width  ALU second operand (divisor, used for the zero check)
mthi  in  1  write mt_data to HI
mtlo  in  1  write mt_data to LO
mt_data  in  data_width  MTHI/MTLO data
mf_req  in  1  MFHI/MFLO read request
mf_sel  in  1  0 = read LO, 1 = read HI
mf_data  out  data_width  read data
stall  out  1  pipeline must hold the current EX instruction
busy  out  1  operation in flight
div_zero  out  1  one-cycle pulse: a DIV/DIVU with in_s2 == 0 completed
hi_out  out  data_width  current HI register
lo_out  out  data_width  current LO register

Behaviour:
- The sole clock is clk. Reset is synchronous and active-low on rst_n.
- Reset: state=IDLE; HI=LO=0; shadow registers=0; counter=0; busy=0; stall=0; div_zero=0; mf_data=0.
- Reset asserted mid-operation abandons the op. HI/LO return to 0 and there is no commit and no div_zero pulse.
- FSM states: IDLE, BUSY.
- IDLE, start=1 with opcode in {11..14}, accept at edge t0:
  - Latch alu_hi/alu_result into shadow registers.
  - Latch dz = (opcode in {13,14}) && in_s2==0.
  - Load counter = MULT_LAT for MULT/MULTU, DIV_LAT for DIV/DIVU.
  - Go to BUSY.
- IDLE, start=1 with any other opcode: ignored, no stall.
- BUSY: busy=1 for exactly L cycles (t0+1 .. t0+L); counter decrements each cycle. At the edge ending the last cycle:
  - If dz=0, HI<=shadow_hi and LO<=shadow_lo.
  - If dz=1, HI/LO are unchanged and div_zero=1 for the following single cycle.
  - State returns to IDLE; new values are visible from cycle t0+L+1.
- stall (combinational) = busy && (mf_req || mthi || mtlo || (start && opcode in {11..14})).
- Requests that arrive while stalled are not performed. Upstream holds them, and they are serviced in the first IDLE cycle.
- mf_data: in IDLE with mf_req=1, mf_data = mf_sel ? HI : LO combinationally, in the same cycle. Otherwise mf_data holds its last value (registered hold).
- MTHI/MTLO in IDLE: the write takes effect at the next edge. mthi and mtlo together write both registers.
- Same IDLE cycle, mf_req + start: the read returns the pre-operation value and start is accepted.
- Same IDLE cycle, mthi/mtlo + start: the mt write happens and start is accepted; the later commit overwrites.
- Same IDLE cycle, mf_req + mthi/mtlo to the same register: the read returns the old value (read-before-write).
- An mf_req in the commit cycle (still BUSY) stalls. The next cycle returns the new value.
- hi_out/lo_out always reflect the architectural registers, never the shadow registers.
- Width rule: all storage is data_width. No arithmetic is performed beyond the counter, which is width clog2(max(MULT_LAT,DIV_LAT)+1).

Decomposition:
- Shared package mips_pkg: ALU opcode constants (ADD=0 .. SLTU=16, MULT=11, MULTU=12, DIV=13, DIVU=14); data_width default; FSM state encoding IDLE/BUSY.
- One natural sub-module: hilo_regs, the HI/LO register pair with mt/commit write ports and the read mux.
- The FSM, counter and stall logic stay in hilo_unit.

Test Plan:
- Reset, then mf_req sel=1 and sel=0 -> mf_data=0, stall=0, busy=0, hi_out=lo_out=0.
- start MULT (11), alu_hi=0xFFFFFFFF, alu_result=0xFFFFFFFD, default MULT_LAT=4 -> busy high exactly 4 cycles; lo_out=0xFFFFFFFD and hi_out=0xFFFFFFFF from cycle 5; an mf_req sel=0 at cycle 2 -> stall=1; the held request returns 0xFFFFFFFD in cycle 5.
- start DIVU (14), in_s2=3, alu_result=0x55555552, alu_hi=2 -> busy 12 cycles, then LO=0x55555552, HI=2; a second start DIV issued during busy -> stall=1 until IDLE, then accepted.
- start DIV, in_s2=0, with prior HI=7, LO=9 -> after 12 cycles HI=7 and LO=9 unchanged, div_zero=1 for exactly one cycle.
- IDLE: mthi=1, mt_data=0x12345678 together with mf_req sel=1 -> mf_data returns the old HI in the same cycle; the next cycle's read returns 0x12345678.
- start MULT, then drop rst_n at cycle 2 for one edge -> HI=LO=0, busy=0, no div_zero, no later commit.
